// File: rtl/rv32_icache.sv
// Direct-mapped read-only instruction cache: 0-cycle hit, whole-line refill over a valid/ready read port.
// Fetch stalls via instr_ready_out while a line fills; mem_read/mem_address hold until mem_ready_in.
module rv32_icache #(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic        instr_read_in,
    input  logic [31:0] instr_address_in,
    output logic [31:0] instr_read_value_out,
    output logic        instr_ready_out,
    input  logic        flush_in,
    output logic        mem_read_out,
    output logic [31:0] mem_address_out,
    input  logic        mem_ready_in,
    input  logic [31:0] mem_read_value_in
);

    localparam int OFF_BITS = $clog2(WORDS_PER_LINE);
    localparam int IDX_BITS = $clog2(LINES);
    localparam int LSB_IDX  = 2 + OFF_BITS;
    localparam int LSB_TAG  = LSB_IDX + IDX_BITS;
    localparam int TAG_BITS = 32 - LSB_TAG;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {S_IDLE, S_FILL} state_t;

    state_t                r_state;
    logic [LINES-1:0]      r_valid;
    logic [TAG_BITS-1:0]   r_tag  [LINES];
    logic [31:0]           r_data [LINES][WORDS_PER_LINE];
    logic [OFF_BITS-1:0]   r_count;
    logic                  r_flush_pending;
    logic [31:0]           r_fill_base;
    logic [IDX_BITS-1:0]   r_fill_index;

    logic [OFF_BITS-1:0]   w_offset;
    logic [IDX_BITS-1:0]   w_index;
    logic [TAG_BITS-1:0]   w_tag;
    logic                  w_hit;
    logic                  w_last;
    logic [31:0]           w_fill_addr;
    logic                  w_unused_bits;

    assign w_offset      = instr_address_in[2 +: OFF_BITS];
    assign w_index       = instr_address_in[LSB_IDX +: IDX_BITS];
    assign w_tag         = instr_address_in[31:LSB_TAG];
    assign w_unused_bits = &{1'b0, instr_address_in[1:0]};

    assign w_hit  = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_last = (r_count == OFF_BITS'(WORDS_PER_LINE - 1));
    assign w_fill_addr = r_fill_base + {{(30 - OFF_BITS){1'b0}}, r_count, 2'b00};

    // The line being refilled is never reported as a hit, even if its old tag still matches.
    assign instr_ready_out = instr_read_in && w_hit && !flush_in
                             && !(r_state == S_FILL && w_index == r_fill_index);
    assign instr_read_value_out = instr_ready_out ? r_data[w_index][w_offset] : NOP;

    assign mem_read_out    = (r_state == S_FILL);
    assign mem_address_out = (r_state == S_FILL) ? w_fill_addr : 32'h0;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state         <= S_IDLE;
            r_valid         <= '0;
            r_count         <= '0;
            r_flush_pending <= 1'b0;
            r_fill_base     <= 32'h0;
            r_fill_index    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (flush_in) begin
                        r_valid <= '0;
                    end else if (instr_read_in && !w_hit) begin
                        r_fill_base      <= {instr_address_in[31:LSB_IDX], {LSB_IDX{1'b0}}};
                        r_fill_index     <= w_index;
                        r_valid[w_index] <= 1'b0;
                        r_count          <= '0;
                        r_state          <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (flush_in)
                        r_flush_pending <= 1'b1;
                    if (mem_ready_in) begin
                        r_count <= r_count + 1'b1;
                        if (w_last) begin
                            r_state         <= S_IDLE;
                            r_flush_pending <= 1'b0;
                            // A flush seen at any point of the fill invalidates the fresh line too.
                            if (r_flush_pending || flush_in)
                                r_valid <= '0;
                            else
                                r_valid[r_fill_index] <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_FILL && mem_ready_in) begin
            r_data[r_fill_index][r_count] <= mem_read_value_in;
            if (w_last)
                r_tag[r_fill_index] <= r_fill_base[31:LSB_TAG];
        end
    end

endmodule

// File: tb/tb_rv32_icache.sv
// Directed bench for rv32_icache: miss/refill timing, hits, conflict, stalled beats, flush and reset.
module tb_rv32_icache;

    logic        clk = 1'b0;
    logic        reset_;
    logic        instr_read_in;
    logic [31:0] instr_address_in;
    logic [31:0] instr_read_value_out;
    logic        instr_ready_out;
    logic        flush_in;
    logic        mem_read_out;
    logic [31:0] mem_address_out;
    logic        mem_ready_in;
    logic [31:0] mem_read_value_in;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        stall_pat  [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] stall_addr [10] = '{32'h100, 32'h104, 32'h104, 32'h104, 32'h108,
                                     32'h108, 32'h108, 32'h10C, 32'h10C, 32'h10C};

    always #5 clk = ~clk;

    // Backing memory: the word at byte address A holds A + 0x93.
    assign mem_read_value_in = mem_address_out + 32'h93;

    rv32_icache #(.LINES(16), .WORDS_PER_LINE(4)) dut (
        .clk                  (clk),
        .reset_               (reset_),
        .instr_read_in        (instr_read_in),
        .instr_address_in     (instr_address_in),
        .instr_read_value_out (instr_read_value_out),
        .instr_ready_out      (instr_ready_out),
        .flush_in             (flush_in),
        .mem_read_out         (mem_read_out),
        .mem_address_out      (mem_address_out),
        .mem_ready_in         (mem_ready_in),
        .mem_read_value_in    (mem_read_value_in)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Miss on base in IDLE, four back-to-back beats, then a hit on base.
    task automatic run_fill(input logic [31:0] base);
        check("miss_ready", 32'(instr_ready_out), 32'd0);
        check("miss_idle_memrd", 32'(mem_read_out), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("fill_memrd", 32'(mem_read_out), 32'd1);
            check("fill_addr", mem_address_out, base + 32'(4 * k));
            check("fill_ready", 32'(instr_ready_out), 32'd0);
        end
        step();
        check("hit_ready", 32'(instr_ready_out), 32'd1);
        check("hit_value", instr_read_value_out, base + 32'h93);
        check("hit_memrd", 32'(mem_read_out), 32'd0);
    endtask

    initial begin
        reset_           = 1'b0;
        instr_read_in    = 1'b0;
        instr_address_in = 32'h0;
        flush_in         = 1'b0;
        mem_ready_in     = 1'b1;
        #3;
        check("rst_ready", 32'(instr_ready_out), 32'd0);
        check("rst_value", instr_read_value_out, NOP);
        check("rst_memrd", 32'(mem_read_out), 32'd0);
        check("rst_memaddr", mem_address_out, 32'h0);
        step();
        step();
        reset_ = 1'b1;

        // Cold miss at 0x0
        instr_read_in    = 1'b1;
        instr_address_in = 32'h0;
        #1;
        run_fill(32'h0);

        // Same-line hits
        instr_address_in = 32'h4;  #1;
        check("hit4_ready", 32'(instr_ready_out), 32'd1);
        check("hit4_value", instr_read_value_out, 32'h97);
        step();
        instr_address_in = 32'h8;  #1;
        check("hit8_value", instr_read_value_out, 32'h9B);
        check("hit8_memrd", 32'(mem_read_out), 32'd0);
        step();
        instr_address_in = 32'hC;  #1;
        check("hitC_value", instr_read_value_out, 32'h9F);
        check("hitC_memrd", 32'(mem_read_out), 32'd0);
        instr_read_in = 1'b0;      #1;
        check("noread_ready", 32'(instr_ready_out), 32'd0);
        check("noread_value", instr_read_value_out, NOP);
        instr_read_in = 1'b1;
        flush_in      = 1'b1;      #1;
        check("flushmask_ready", 32'(instr_ready_out), 32'd0);
        check("flushmask_value", instr_read_value_out, NOP);
        flush_in      = 1'b0;      #1;
        check("unflush_ready", 32'(instr_ready_out), 32'd1);
        step();

        // Conflict on index 0, then the original line misses again
        instr_address_in = 32'h100; #1;
        run_fill(32'h100);
        instr_address_in = 32'h0;   #1;
        run_fill(32'h0);

        // Stalled beats refilling 0x100 via 0x104
        instr_address_in = 32'h104; #1;
        check("stall_miss", 32'(instr_ready_out), 32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            mem_ready_in = stall_pat[i];
            #1;
            check("stall_memrd", 32'(mem_read_out), 32'd1);
            check("stall_addr", mem_address_out, stall_addr[i]);
        end
        step();
        mem_ready_in = 1'b1;
        #1;
        check("stall_done_memrd", 32'(mem_read_out), 32'd0);
        check("stall_hit_ready", 32'(instr_ready_out), 32'd1);
        check("stall_w1", instr_read_value_out, 32'h197);
        instr_address_in = 32'h100; #1;
        check("stall_w0", instr_read_value_out, 32'h193);
        instr_address_in = 32'h108; #1;
        check("stall_w2", instr_read_value_out, 32'h19B);
        instr_address_in = 32'h10C; #1;
        check("stall_w3", instr_read_value_out, 32'h19F);
        step();

        // Second valid line, then flush pulsed during the third beat of a fill
        instr_address_in = 32'h10; #1;
        run_fill(32'h10);
        instr_address_in = 32'h20; #1;
        check("flfill_miss", 32'(instr_ready_out), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            flush_in = (i == 2);
            #1;
            check("flfill_memrd", 32'(mem_read_out), 32'd1);
            check("flfill_addr", mem_address_out, 32'h20 + 32'(4 * i));
        end
        step();
        flush_in = 1'b0;
        #1;
        check("flfill_done", 32'(mem_read_out), 32'd0);
        check("flfill_line_miss", 32'(instr_ready_out), 32'd0);
        instr_address_in = 32'h10;  #1;
        check("flfill_l1_miss", 32'(instr_ready_out), 32'd0);
        instr_address_in = 32'h104; #1;
        check("flfill_l0_miss", 32'(instr_ready_out), 32'd0);

        // Flush in IDLE takes priority over a miss
        instr_address_in = 32'h0;
        flush_in         = 1'b1;
        step();
        check("flush_idle_nofill", 32'(mem_read_out), 32'd0);
        flush_in = 1'b0;

        // Reset in the middle of a fill
        step();
        check("rstfill_memrd0", 32'(mem_read_out), 32'd1);
        step();
        check("rstfill_addr1", mem_address_out, 32'h4);
        reset_ = 1'b0;
        #1;
        check("rstfill_memrd", 32'(mem_read_out), 32'd0);
        check("rstfill_memaddr", mem_address_out, 32'h0);
        check("rstfill_ready", 32'(instr_ready_out), 32'd0);
        reset_ = 1'b1;
        #1;
        check("postrst_miss0", 32'(instr_ready_out), 32'd0);
        instr_address_in = 32'h104; #1;
        check("postrst_miss104", 32'(instr_ready_out), 32'd0);
        instr_address_in = 32'h10;  #1;
        check("postrst_miss10", 32'(instr_ready_out), 32'd0);
        instr_read_in = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32_icache.md
# rv32_icache

Instruction-side responder for the fetch stage's memory-bus read port: a direct-mapped, read-only instruction cache. It answers fetch reads combinationally on a hit and reports a miss so the hazard unit can stall fetch. It refills whole lines from a backing memory over a valid/ready read handshake and supports full invalidation for `fence.i`.

## Interface
- `LINES`, 16, number of cache lines; power of two, ≥2.
- `WORDS_PER_LINE`, 4, 32-bit words per line; power of two, ≥2.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset_`  in  1  asynchronous, active-low reset.
- `instr_read_in`  in  1  fetch read request.
- `instr_address_in`  in  32  fetch byte address; bits [1:0] are ignored.
- `instr_read_value_out`  out  32  instruction word; `32'h00000013` (NOP) when not ready.
- `instr_ready_out`  out  1  high when the value is valid this cycle (hit); goes to hazard stall logic.
- `flush_in`  in  1  invalidate all lines.
- `mem_read_out`  out  1  backing-memory read request.
- `mem_address_out`  out  32  backing-memory word address (byte address, word aligned).
- `mem_ready_in`  in  1  backing memory has data this cycle.
- `mem_read_value_in`  in  32  backing-memory read data.

## Operation
- Address split:
  - Byte bits [1:0].
  - Word offset: `$clog2(WORDS_PER_LINE)` bits.
  - Index: `$clog2(LINES)` bits.
  - Tag: the remaining upper bits.
- Per-line state: valid bit, tag, `WORDS_PER_LINE` data words. Only the valid bits are reset.
- Hit: `valid[index] && tag[index] == addr_tag`.
- `instr_ready_out = instr_read_in && hit && !flush_in && !(state == FILL && index == fill_index)`.
- `instr_read_value_out` = selected data word when `instr_ready_out` is high, else NOP.
- FSM states: IDLE and FILL.
- IDLE, evaluated in priority order:
  - `flush_in` high: clear all valid bits at the edge; no fill starts.
  - Else if `instr_read_in && !hit`: latch `fill_base = {addr[31:OFFSET_BITS], 0}`, latch `fill_index`, clear `valid[fill_index]`, set word counter to 0, go to FILL.
- FILL:
  - `mem_read_out = 1`, `mem_address_out = fill_base + 4*count`. Both hold stable until `mem_ready_in` is sampled high.
  - On each edge with `mem_ready_in` high: write `mem_read_value_in` into word `count`, then increment `count`.
  - On the last word: write the tag. Set the valid bit only if `flush_pending` is 0. Clear `flush_pending`, then go to IDLE.
- `flush_in` during FILL sets `flush_pending`; the fill is never aborted mid-handshake.
  - At fill completion with `flush_pending` set, all valid bits are cleared, including the line just filled.
  - A flush asserted on the completing edge itself also clears all valid bits.
- A fetch address change during FILL (e.g. a branch redirect) does not affect the fill in progress. After returning to IDLE, a new miss on the new address starts its own fill.
- `instr_read_in` low: no hit is reported and no fill starts.
- In IDLE, `mem_read_out = 0` and `mem_address_out = 0`.

## Timing
- Reset (async, `reset_` low):
  - State IDLE, all valid bits 0, `count` 0, `flush_pending` 0, `fill_base` 0.
  - Hence `instr_ready_out = 0`, `instr_read_value_out = NOP`, `mem_read_out = 0`, `mem_address_out = 0`.
  - Reset mid-FILL abandons the transfer immediately; memory must tolerate a dropped request.
- Hit latency: 0 cycles (combinational from address to data/ready).
- Miss timing, with detection in cycle N:
  - FILL starts in cycle N+1.
  - With `mem_ready_in` held high, words transfer in cycles N+1 … N+`WORDS_PER_LINE`.
  - The line becomes valid at the end of that last cycle.
  - First hit is in cycle N+`WORDS_PER_LINE`+1. Minimum miss penalty is `WORDS_PER_LINE`+1 cycles.
- Each `mem_ready_in` low cycle extends FILL by one cycle.
- `count` is `$clog2(WORDS_PER_LINE)` bits wide and wraps to 0 on the last word.
- `fill_base + 4*count` never carries out of the line.

## Test plan
- Reset, then read 0x00000000 with memory returning 0x00000093+4·k and `mem_ready_in` held 1:
  - `instr_ready_out` is 0 for 5 cycles.
  - `mem_address_out` steps 0x0, 0x4, 0x8, 0xC.
  - Cycle 6 returns 0x00000093 with ready 1.
- After that fill, read 0x4, 0x8, 0xC: all hit with zero latency, returning the 2nd–4th words; `mem_read_out` stays 0.
- Conflict miss: read 0x100 (same index 0, tag differs):
  - Refills from 0x100.
  - A subsequent read of 0x0 misses again.
- `mem_ready_in` toggling 1,0,0,1,…:
  - `mem_address_out` holds 0x104 through the stall cycles.
  - All 4 words are captured correctly; the fill ends after 4 accepted beats.
- `flush_in` pulsed during the third beat of a fill:
  - The fill completes.
  - The next read of the same address misses, and so do all previously valid lines.
- Assert `reset_` low mid-FILL: `mem_read_out` drops to 0 immediately, and after release every read misses.
